// File: rtl/counter_timer.sv
// Load-triggered programmable delay timer: dn rises once more than n cycles have elapsed since ld.
// Optional pause input enabled by defining COUNTER_TIMER_HOLD_EN.
module counter_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] n,
`ifdef COUNTER_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic             dn,
  output logic             busy,
  output logic [WIDTH-1:0] left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             hold_w;

`ifdef COUNTER_TIMER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // ld restarts from any state and takes priority over hold.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (ld) begin
      if (n == '0) begin
        state_d = DONE;
        rem_d   = '0;
      end else begin
        state_d = COUNT;
        rem_d   = n - 1'b1;
      end
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        COUNT: begin
          if (!hold_w) begin
            if (rem_q == '0) state_d = DONE;
            else             rem_d   = rem_q - 1'b1;
          end
        end
        DONE:  state_d = DONE;
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign dn   = (state_q == DONE) && !ld;
  assign busy = (state_q == COUNT);
  assign left = (state_q == COUNT) ? rem_q : '0;

endmodule

// File: tb/tb_counter_timer.sv
// Directed bench for counter_timer (WIDTH=7); hold scenario runs only when COUNTER_TIMER_HOLD_EN is defined.
module tb_counter_timer;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] n   = '0;
`ifdef COUNTER_TIMER_HOLD_EN
  logic         hold = 1'b0;
`endif
  logic         dn;
  logic         busy;
  logic [W-1:0] left;

  int checks = 0;
  int errors = 0;

  counter_timer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .n    (n),
`ifdef COUNTER_TIMER_HOLD_EN
    .hold (hold),
`endif
    .dn   (dn),
    .busy (busy),
    .left (left)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    ld = 1'b1;
    n  = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({dn, busy, left} !== {1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset_state: got dn=%b busy=%b left=%0d want 0/0/0", dn, busy, left);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      next_cycle();
      n = W'($urandom_range(0, 127));
      #1;
      checks++;
      if ({dn, busy, left} !== {1'b0, 1'b0, 7'd0}) begin
        errors++;
        $display("FAIL idle_k%0d: got dn=%b busy=%b left=%0d want 0/0/0", k, dn, busy, left);
      end
    end
  endtask

  // Generic count-down run; n is scrambled while ld=0 to show it is ignored.
  task automatic test_count(input int nv, input int extra);
    int exp_left;
    load(W'(nv));
    #1;
    checks++;
    if (dn !== 1'b0) begin
      errors++;
      $display("FAIL ld_cycle_n%0d: got dn=%b want 0", nv, dn);
    end
    for (int k = 1; k <= nv + 1 + extra; k++) begin
      next_cycle();
      n = W'($urandom_range(0, 127));
      #1;
      exp_left = (k <= nv) ? nv - k : 0;
      checks++;
      if ({dn, busy, left} !== {(k > nv), (k <= nv), W'(exp_left)}) begin
        errors++;
        $display("FAIL count_n%0d_k%0d: got dn=%b busy=%b left=%0d want %b/%b/%0d",
                 nv, k, dn, busy, left, (k > nv), (k <= nv), exp_left);
      end
    end
  endtask

  task automatic test_restart();
    load(7'd91);
    for (int k = 1; k < 50; k++) next_cycle();
    load(7'd10);
    #1;
    checks++;
    if (dn !== 1'b0 || busy !== 1'b1 || left !== 7'd41) begin
      errors++;
      $display("FAIL restart_ld: got dn=%b busy=%b left=%0d want 0/1/41", dn, busy, left);
    end
    for (int k = 1; k <= 50; k++) begin
      next_cycle();
      #1;
      checks++;
      if (dn !== (k > 10)) begin
        errors++;
        $display("FAIL restart_k%0d: got dn=%b want %b", k, dn, (k > 10));
      end
    end
    // Now at t+100 in DONE: ld must force dn low in its own cycle.
    load(7'd5);
    #1;
    checks++;
    if (dn !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ld_in_done: got dn=%b busy=%b want 0/0", dn, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      #1;
      checks++;
      if (dn !== (k > 5)) begin
        errors++;
        $display("FAIL done_reload_k%0d: got dn=%b want %b", k, dn, (k > 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      load((k % 2 == 0) ? 7'd0 : 7'd3);
      #1;
      checks++;
      if (dn !== 1'b0) begin
        errors++;
        $display("FAIL b2b_k%0d: got dn=%b want 0", k, dn);
      end
    end
    // Last load was n=3.
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      #1;
      checks++;
      if (dn !== (k > 3)) begin
        errors++;
        $display("FAIL b2b_tail_k%0d: got dn=%b want %b", k, dn, (k > 3));
      end
    end
  endtask

  task automatic test_mid_reset();
    load(7'd91);
    for (int k = 1; k <= 40; k++) next_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dn, busy, left} !== {1'b0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL async_reset: got dn=%b busy=%b left=%0d want 0/0/0", dn, busy, left);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      #1;
      checks++;
      if ({dn, busy, left} !== {1'b0, 1'b0, 7'd0}) begin
        errors++;
        $display("FAIL post_reset_k%0d: got dn=%b busy=%b left=%0d want 0/0/0", k, dn, busy, left);
      end
    end
  endtask

`ifdef COUNTER_TIMER_HOLD_EN
  task automatic test_hold();
    load(7'd20);
    for (int k = 1; k <= 40; k++) begin
      next_cycle();
      hold = (k >= 5 && k <= 14);
      #1;
      checks++;
      if (dn !== (k >= 31)) begin
        errors++;
        $display("FAIL hold_k%0d: got dn=%b want %b", k, dn, (k >= 31));
      end
    end
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      checks++;
      if (dn !== 1'b1) begin
        errors++;
        $display("FAIL hold_in_done_k%0d: got dn=%b want 1", k, dn);
      end
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count(91, 10);
    test_count(0, 3);
    test_count(1, 2);
    test_count(127, 3);
    test_restart();
    test_back_to_back();
    test_mid_reset();
`ifdef COUNTER_TIMER_HOLD_EN
    test_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
